load_store_unit: RTL and testbench

Multi-cycle memory access stage directly downstream of the arithmetic/logic unit: it takes the ALU result as the effective address and performs one byte/half/word load or store on the data bus through a valid/ready handshake. Stores get lane replication and write strobes; loads get lane extraction with sign or zero extension. The control sequencer stalls on `busy` and retires the instruction on `done`.

---
 rtl/load_store_unit_pkg.sv | 11 +
 rtl/load_store_unit_load_extract.sv | 16 +
 rtl/load_store_unit.sv | 82 ++++++++
 tb/tb_load_store_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared LSU types and store lane helpers
package load_store_unit_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2} mem_size_t;
  function automatic logic [3:0] store_strobe(input mem_size_t size, input logic [1:0] off);
    return size == MEM_BYTE ? 4'b0001 << off : size == MEM_HALF ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction
  function automatic word_t store_wdata(input mem_size_t size, input word_t d);
    return size == MEM_BYTE ? {4{d[7:0]}} : size == MEM_HALF ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/load_store_unit_load_extract.sv
// load_extract: selects the addressed byte/half lane of a bus word and extends it
module load_extract import load_store_unit_pkg::*; (
  input  word_t      rdata,
  input  logic [1:0] offset,
  input  mem_size_t  size,
  input  logic       sign_ext,
  output word_t      data
);
  word_t shifted;
  // shift the addressed lane down to bit 0, then sign or zero extend it
  always_comb begin
    shifted = size == MEM_BYTE ? rdata >> {offset, 3'b000} : size == MEM_HALF ? rdata >> {offset[1], 4'b0000} : rdata;
    data = size == MEM_BYTE ? {{24{sign_ext & shifted[7]}}, shifted[7:0]} :
           size == MEM_HALF ? {{16{sign_ext & shifted[15]}}, shifted[15:0]} : shifted;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store stage over a valid/ready bus (LSU_MISALIGN_CHECK_EN enables misalignment rejection)
module load_store_unit import load_store_unit_pkg::*; (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       is_store,
  input  mem_size_t  size,
  input  logic       sign_ext,
  input  word_t      address,
  input  word_t      store_data,
  output logic       busy,
  output logic       done,
  output word_t      load_data,
  output logic       misaligned,
  output logic       mem_valid,
  input  logic       mem_ready,
  output word_t      mem_address,
  output logic [3:0] mem_wstrobe,
  output word_t      mem_wdata,
  input  word_t      mem_rdata
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t     state;
  mem_size_t  r_size;
  logic       r_sign_ext;
  logic       r_is_store;
  logic [1:0] r_off;
  logic       reject;
  word_t      extracted;
`ifdef LSU_MISALIGN_CHECK_EN
  assign reject = size == MEM_HALF ? address[0] : size == MEM_BYTE ? 1'b0 : |address[1:0];
`else
  assign reject = 1'b0;
`endif
  assign busy = state == ACCESS;
  load_extract u_extract (
    .rdata    (mem_rdata),
    .offset   (r_off),
    .size     (r_size),
    .sign_ext (r_sign_ext),
    .data     (extracted)
  );
  // accept a request in IDLE, hold the bus request until ready, pulse done on retirement
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      done        <= 1'b0;
      misaligned  <= 1'b0;
      mem_valid   <= 1'b0;
      mem_address <= '0;
      mem_wstrobe <= '0;
      mem_wdata   <= '0;
      load_data   <= '0;
      r_size      <= MEM_BYTE;
      r_sign_ext  <= 1'b0;
      r_is_store  <= 1'b0;
      r_off       <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      if (state == IDLE && start && reject) begin
        done       <= 1'b1;
        misaligned <= 1'b1;
      end else if (state == IDLE && start) begin
        state       <= ACCESS;
        mem_valid   <= 1'b1;
        mem_address <= {address[31:2], 2'b00};
        mem_wstrobe <= is_store ? store_strobe(size, address[1:0]) : 4'b0000;
        mem_wdata   <= store_wdata(size, store_data);
        r_size      <= size;
        r_sign_ext  <= sign_ext;
        r_is_store  <= is_store;
        r_off       <= address[1:0];
      end else if (state == ACCESS && mem_ready) begin
        state     <= IDLE;
        mem_valid <= 1'b0;
        done      <= 1'b1;
        if (!r_is_store) load_data <= extracted;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  logic       clk = 0, reset_n = 0, start = 0, is_store = 0, sign_ext = 0, mem_ready = 0;
  mem_size_t  size = MEM_BYTE;
  word_t      address = 0, store_data = 0, mem_rdata = 0;
  logic       busy, done, misaligned, mem_valid;
  word_t      load_data, mem_address, mem_wdata;
  logic [3:0] mem_wstrobe;
  int         vecs = 0, errs = 0, cyc = 0;
  word_t      exp_ld = 0;
  typedef struct {logic [31:0] a; logic [3:0] s; logic [31:0] d; bit st; int c;} bus_t;
  typedef struct {bit mis; logic [31:0] ld; int c;} cmp_t;
  bus_t bus_q[$];
  cmp_t cmp_q[$];

  load_store_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .address(address), .store_data(store_data), .busy(busy),
    .done(done), .load_data(load_data), .misaligned(misaligned), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_address(mem_address), .mem_wstrobe(mem_wstrobe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: compares every bus request and every completion against the queued expectations
  logic  pv = 0;
  word_t pa = 0, pd = 0;
  logic [3:0] ps = 0;
  bus_t  mb;
  cmp_t  mc;
  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy_vs_valid", busy, mem_valid);
      if (mem_valid && !pv) begin
        if (bus_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL bus_unexpected: mem_valid rose at address %h with no request pending", mem_address);
        end else begin
          mb = bus_q.pop_front();
          chk("mem_address", mem_address, mb.a);
          chk("mem_wstrobe", mem_wstrobe, {28'd0, mb.s});
          if (mb.st) chk("mem_wdata", mem_wdata, mb.d);
          chk("bus_cycle", cyc, mb.c);
        end
      end else if (mem_valid) begin
        chk("hold_address", mem_address, pa);
        chk("hold_wstrobe", {28'd0, mem_wstrobe}, {28'd0, ps});
        chk("hold_wdata", mem_wdata, pd);
      end
      if (done) begin
        if (cmp_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL done_unexpected: done with no request pending");
        end else begin
          mc = cmp_q.pop_front();
          chk("misaligned", misaligned, mc.mis);
          chk("load_data", load_data, mc.ld);
          chk("done_cycle", cyc, mc.c);
          chk("busy_at_done", busy, 1'b0);
        end
      end else chk("misaligned_without_done", misaligned, 1'b0);
    end
    pv = mem_valid; pa = mem_address; ps = mem_wstrobe; pd = mem_wdata;
  end

  // issue one request, act as the bus slave, and return in the done cycle
  task automatic op(input bit st, input int sz, input bit se, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] rd, input int waits);
    int n, off;
    bit mis;
    bus_t b;
    cmp_t e;
    logic [31:0] v;
    n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    off = int'(a[1:0]) / n * n;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = (int'(a[1:0]) % n) != 0;
`else
    mis = 1'b0;
`endif
    is_store = st; size = mem_size_t'(2'(sz)); sign_ext = se; address = a; store_data = d; start = 1;
    e.mis = mis;
    if (mis) begin
      e.ld = exp_ld; e.c = cyc + 1;
      cmp_q.push_back(e);
      @(posedge clk); #1;
      start = 0; address = $urandom;
      return;
    end
    b.a = a & ~32'h3; b.s = 4'b0; b.st = st; b.c = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (st && i >= off && i < off + n) b.s[i] = 1'b1;
      b.d[8*i+:8] = d[8*(i%n)+:8];
    end
    bus_q.push_back(b);
    if (!st) begin
      v = 0;
      for (int j = 0; j < n; j++) v[8*j+:8] = rd[8*(off+j)+:8];
      if (se && n < 4 && v[8*n-1]) for (int j = n; j < 4; j++) v[8*j+:8] = 8'hFF;
      exp_ld = v;
    end
    e.ld = exp_ld; e.c = cyc + 2 + waits;
    cmp_q.push_back(e);
    @(posedge clk); #1;
    start = 0; address = $urandom; store_data = $urandom; is_store = $urandom; sign_ext = $urandom;
    size = mem_size_t'(2'($urandom_range(0, 3)));
    repeat (waits) begin @(posedge clk); #1; end
    mem_ready = 1; mem_rdata = rd;
    @(posedge clk); #1;
    mem_ready = 0; mem_rdata = $urandom;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_misaligned", misaligned, 1'b0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wstrobe", {28'd0, mem_wstrobe}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    reset_n = 1;
    op(1, 2, 0, 32'h100, 32'h11223344, 32'h0, 2);
    op(1, 0, 0, 32'h103, 32'h000000AB, 32'h0, 0);
    op(0, 0, 1, 32'h201, 32'h0, 32'h0000F000, 1);
    chk("tp_lb_sext", load_data, 32'hFFFFFFF0);
    op(0, 0, 0, 32'h201, 32'h0, 32'h0000F000, 0);
    chk("tp_lb_zext", load_data, 32'h000000F0);
    op(0, 1, 1, 32'h302, 32'h0, 32'h80011234, 0);
    chk("tp_lh_sext", load_data, 32'hFFFF8001);
    op(0, 2, 0, 32'h300, 32'h0, 32'h80011234, 0);
    chk("tp_lw_b2b", load_data, 32'h80011234);
    op(0, 2, 0, 32'h401, 32'h0, 32'hCAFEF00D, 1);
    op(0, 1, 1, 32'h501, 32'h0, 32'h00FF8000, 0);
    // reset while waiting on the bus
    @(posedge clk); #1;
    is_store = 0; size = MEM_WORD; address = 32'h600; start = 1;
    mb.a = 32'h600; mb.s = 4'b0; mb.d = 0; mb.st = 0; mb.c = cyc + 1;
    bus_q.push_back(mb);
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1'b1);
    reset_n = 0;
    #1;
    chk("arst_mem_valid", mem_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_load_data", load_data, 32'h0);
    exp_ld = 0;
    @(posedge clk); #1;
    reset_n = 1;
    op(0, 1, 0, 32'h702, 32'h0, 32'hBEEF0000, 1);
    chk("post_rst_load", load_data, 32'h0000BEEF);
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom, $urandom, $urandom,
         $urandom_range(0, 3));
    end
    repeat (4) @(posedge clk);
    #1;
    if (bus_q.size() != 0 || cmp_q.size() != 0) begin
      vecs++; errs++;
      $display("FAIL leftover: %0d bus and %0d completion expectations never seen", bus_q.size(), cmp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
